// File: rtl/tanh_job_sequencer_if.sv
// Bundle of the sample, core and result signals of tanh_job_sequencer.
// slave  : the sequencer side.
// master : the environment side (sample source, tanh core and consumer).
interface tanh_job_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] in_data;
   logic        core_start;
   logic [16:0] core_data_x;
   logic        core_done;
   logic [31:0] core_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        err_timeout;
   logic        busy;

   modport slave (
      input  in_valid, in_data, core_done, core_result, out_ready,
      output in_ready, core_start, core_data_x, out_valid, out_data, err_timeout, busy
   );

   modport master (
      output in_valid, in_data, core_done, core_result, out_ready,
      input  in_ready, core_start, core_data_x, out_valid, out_data, err_timeout, busy
   );
endinterface

// File: rtl/tanh_job_sequencer.sv
// tanh_job_sequencer: buffers x samples in a small FIFO, runs one tanh core
// job per sample (start / data_x / done / result) and returns each result on
// a valid/ready stream. A core that never answers is cut off after
// TIMEOUT_CYCLES and reported as a zero result plus a sticky err_timeout.
// Optional build macro: TANH_SEQ_SIGN_FIX_EN -- the core only sees |x| and
// the sequencer negates the result for negative samples.
module tanh_job_sequencer #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   tanh_job_sequencer_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

   logic [16:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          push, pop, fifo_empty;

   state_t        state_q, state_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [16:0]   dx_q, dx_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_data_q, out_data_d;
   logic          err_q, err_d;
   logic          done_q;
   logic          done_rise;
`ifdef TANH_SEQ_SIGN_FIX_EN
   logic          sign_q, sign_d;
`endif

   assign fifo_empty = (count_q == '0);
   assign push       = bus.in_valid & bus.in_ready;
   // Only IDLE pops, so a job never overlaps the next one.
   assign pop        = (state_q == IDLE) & ~fifo_empty;
   assign done_rise  = bus.core_done & ~done_q;

   // FIFO storage: write at the tail on an accepted push.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_data;
   end

   // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // FSM and job registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tcnt_q      <= '0;
         dx_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
`ifdef TANH_SEQ_SIGN_FIX_EN
         sign_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         dx_q        <= dx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
         done_q      <= bus.core_done;
`ifdef TANH_SEQ_SIGN_FIX_EN
         sign_q      <= sign_d;
`endif
      end
   end

   // Next-state logic: pop -> start pulse -> wait for done edge or timeout -> hand off.
   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      dx_d        = dx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      err_d       = err_q;
`ifdef TANH_SEQ_SIGN_FIX_EN
      sign_d      = sign_q;
`endif
      case (state_q)
         IDLE: begin
            if (pop) begin
`ifdef TANH_SEQ_SIGN_FIX_EN
               dx_d   = {1'b0, mem_q[rd_ptr_q][15:0]};
               sign_d = mem_q[rd_ptr_q][16];
`else
               dx_d   = mem_q[rd_ptr_q];
`endif
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            tcnt_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            tcnt_d = tcnt_q + 1'b1;
            // A done edge beats a timeout landing in the same cycle.
            if (done_rise) begin
`ifdef TANH_SEQ_SIGN_FIX_EN
               out_data_d = sign_q ? (32'd0 - bus.core_result) : bus.core_result;
`else
               out_data_d = bus.core_result;
`endif
               out_valid_d = 1'b1;
               state_d     = DELIVER;
            end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d       = 1'b1;
               out_data_d  = '0;
               out_valid_d = 1'b1;
               state_d     = DELIVER;
            end
         end
         DELIVER: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready    = (count_q != CW'(DEPTH));
   assign bus.core_start  = (state_q == ISSUE);
   assign bus.core_data_x = dx_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.err_timeout = err_q;
   assign bus.busy        = (state_q != IDLE) | ~fifo_empty;
endmodule

// File: tb/tb_tanh_job_sequencer.sv
// Directed bench for tanh_job_sequencer with a behavioural tanh core model.
module tb_tanh_job_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   tanh_job_sequencer_if bus();

   tanh_job_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Core model controls.
   int          delay      = 13;
   logic        stale_mode = 1'b0;
   logic        never_done = 1'b0;
   logic        force_en   = 1'b0;
   logic [31:0] force_val  = '0;
   logic        active, drop;
   int          cnt;
   logic [16:0] xin;
   int          start_cnt;

   // Core result function: x[15:0]=8000 -> 7660, otherwise x + 0001_0000.
   function automatic logic [31:0] core_f(input logic [16:0] x);
      if (x[15:0] == 16'h8000) return 32'h0000_7660;
      return {15'h0, x} + 32'h0001_0000;
   endfunction

   // Behavioural core: done level rises `delay` cycles after start, drops at
   // the next start (or one cycle later in stale mode).
   always @(posedge clk) begin
      if (rst) begin
         bus.core_done   <= 1'b0;
         bus.core_result <= '0;
         active <= 1'b0;
         drop   <= 1'b0;
         cnt    <= 0;
         xin    <= '0;
         start_cnt <= 0;
      end else if (bus.core_start) begin
         start_cnt <= start_cnt + 1;
         active <= !never_done;
         cnt    <= delay;
         xin    <= bus.core_data_x;
         if (!stale_mode) bus.core_done <= 1'b0;
         drop   <= stale_mode;
      end else begin
         if (drop) begin
            bus.core_done <= 1'b0;
            drop <= 1'b0;
         end
         if (active) begin
            if (cnt <= 1) begin
               bus.core_done   <= 1'b1;
               bus.core_result <= force_en ? force_val : core_f(xin);
               active <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [16:0] d);
      logic rdy;
      int   n;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      rdy = 1'b0;
      n   = 0;
      while (!rdy && n < 500) begin
         rdy = bus.in_ready;
         step();
         n++;
      end
      bus.in_valid = 1'b0;
      chk("push_accepted", {31'd0, rdy}, 32'd1);
   endtask

   task automatic wait_start();
      int n;
      n = 0;
      while (!bus.core_start && n < 100) begin
         step();
         n++;
      end
      chk("core_start_seen", {31'd0, bus.core_start}, 32'd1);
   endtask

   // Collect n results with out_ready held high and compare in order.
   task automatic collect(input int n, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3,
                          input logic [31:0] e4, input logic [31:0] e5);
      logic [31:0] exp [6];
      int got;
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3; exp[4] = e4; exp[5] = e5;
      got = 0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 2000 && got < n; c++) begin
         if (bus.out_valid) begin
            chk($sformatf("result_%0d", got), bus.out_data, exp[got]);
            got++;
         end
         step();
      end
      chk("result_count", got, n);
   endtask

   int          base;
   int          n;
   logic        dx_ok;
   logic        seen;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      step();
      step();
      // Reset values.
      chk("rst_in_ready",    {31'd0, bus.in_ready},    32'd1);
      chk("rst_core_start",  {31'd0, bus.core_start},  32'd0);
      chk("rst_core_data_x", {15'd0, bus.core_data_x}, 32'd0);
      chk("rst_out_valid",   {31'd0, bus.out_valid},   32'd0);
      chk("rst_out_data",    bus.out_data,             32'd0);
      chk("rst_err_timeout", {31'd0, bus.err_timeout}, 32'd0);
      chk("rst_busy",        {31'd0, bus.busy},        32'd0);
      rst = 1'b0;
      step();

      // Single job.
      bus.out_ready = 1'b1;
      delay = 13;
      base = start_cnt;
      push(17'h08000);
      wait_start();
      step();
      dx_ok = 1'b1;
      n = 0;
      while (!bus.out_valid && n < 100) begin
         if (bus.core_data_x !== 17'h08000) dx_ok = 1'b0;
         step();
         n++;
      end
      chk("single_dx_stable", {31'd0, dx_ok}, 32'd1);
      chk("single_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("single_out_data",  bus.out_data, 32'h0000_7660);
      chk("single_err",       {31'd0, bus.err_timeout}, 32'd0);
      step();
      chk("single_valid_drop", {31'd0, bus.out_valid}, 32'd0);
      chk("single_start_cnt", start_cnt - base, 32'd1);

      // Stale done: done still high from the last job, falls after start.
      stale_mode = 1'b1;
      force_en   = 1'b1;
      force_val  = 32'h0000_1234;
      delay      = 6;
      chk("stale_done_high", {31'd0, bus.core_done}, 32'd1);
      push(17'h00100);
      collect(1, 32'h0000_1234, 0, 0, 0, 0, 0);
      stale_mode = 1'b0;
      force_en   = 1'b0;

      // FIFO full / backpressure.
      bus.out_ready = 1'b0;
      delay = 5;
      base  = start_cnt;
      for (int i = 1; i <= 5; i++) push(17'(i));
      chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      for (int i = 0; i < 10; i++) step();
      chk("full_in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
      chk("full_out_valid",     {31'd0, bus.out_valid}, 32'd1);
      chk("full_busy",          {31'd0, bus.busy}, 32'd1);
      fork
         push(17'h00006);
         collect(6, 32'h0001_0001, 32'h0001_0002, 32'h0001_0003,
                    32'h0001_0004, 32'h0001_0005, 32'h0001_0006);
      join
      chk("full_start_cnt", start_cnt - base, 32'd6);

      // Sign handling.
      push(17'h18000);
      wait_start();
      step();
`ifdef TANH_SEQ_SIGN_FIX_EN
      chk("sign_core_data_x", {15'd0, bus.core_data_x}, 32'h0000_8000);
      collect(1, 32'hFFFF_89A0, 0, 0, 0, 0, 0);
`else
      chk("sign_core_data_x", {15'd0, bus.core_data_x}, 32'h0001_8000);
      collect(1, 32'h0000_7660, 0, 0, 0, 0, 0);
`endif

      // Timeout: 64 WAIT cycles, then zero result and sticky error.
      never_done = 1'b1;
      bus.out_ready = 1'b0;
      push(17'h00002);
      wait_start();
      n = 0;
      while (!bus.out_valid && n < 200) begin
         step();
         n++;
      end
      chk("timeout_latency", n, 32'd65);
      chk("timeout_out_data", bus.out_data, 32'd0);
      chk("timeout_err", {31'd0, bus.err_timeout}, 32'd1);
      never_done = 1'b0;
      collect(1, 32'd0, 0, 0, 0, 0, 0);
      push(17'h00003);
      collect(1, 32'h0001_0003, 0, 0, 0, 0, 0);
      chk("timeout_err_sticky", {31'd0, bus.err_timeout}, 32'd1);

      // Reset mid-WAIT with two samples queued.
      never_done = 1'b1;
      push(17'h00007);
      push(17'h00008);
      push(17'h00009);
      for (int i = 0; i < 5; i++) step();
      chk("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      step();
      chk("midrst_in_ready",    {31'd0, bus.in_ready},    32'd1);
      chk("midrst_core_start",  {31'd0, bus.core_start},  32'd0);
      chk("midrst_core_data_x", {15'd0, bus.core_data_x}, 32'd0);
      chk("midrst_out_valid",   {31'd0, bus.out_valid},   32'd0);
      chk("midrst_out_data",    bus.out_data,             32'd0);
      chk("midrst_err",         {31'd0, bus.err_timeout}, 32'd0);
      chk("midrst_busy",        {31'd0, bus.busy},        32'd0);
      rst = 1'b0;
      never_done = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (bus.out_valid || bus.core_start) seen = 1'b1;
         step();
      end
      chk("midrst_no_delivery", {31'd0, seen}, 32'd0);
      chk("midrst_no_start", start_cnt, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
